// File: rtl/multi_channel_sync_filter.sv
// Multi-channel level synchronizer with persistence filter, edge pulses and
// saturating per-channel edge counters. All state lives in the clk_B domain.
module multi_channel_sync_filter #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                    clk_B,
    input  logic                    reset_B,
    input  logic [NUM_CH-1:0]       async_in,
    input  logic                    clear_cnt,
    output logic [NUM_CH-1:0]       sync_out,
    output logic [NUM_CH-1:0]       rise_pulse,
    output logic [NUM_CH-1:0]       fall_pulse,
    output logic [NUM_CH*CNT_W-1:0] edge_cnt,
    output logic [NUM_CH-1:0]       cnt_sat
);

    localparam int unsigned          FCNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [FCNT_W-1:0]    FILT_LAST = FCNT_W'(FILTER_LEN - 1);

    // Stage 0 is the only flop that samples async_in; the last stage feeds the filter.
    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
    logic [FCNT_W-1:0]      filt_q [NUM_CH];
    logic [FCNT_W-1:0]      filt_d [NUM_CH];
    logic [CNT_W-1:0]       cnt_q  [NUM_CH];
    logic [CNT_W-1:0]       cnt_d  [NUM_CH];
    logic [NUM_CH-1:0]      out_q, out_d;
    logic [NUM_CH-1:0]      rise_q, rise_d;
    logic [NUM_CH-1:0]      fall_q, fall_d;
    logic [NUM_CH-1:0]      sat_q, sat_d;

    // Next-state for synchronizer, filter, edge pulses and edge counters, per channel.
    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        sat_d  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
            filt_d[i] = '0;
            cnt_d[i]  = cnt_q[i];

            // Filter counts consecutive cycles of disagreement; accepting on the
            // FILTER_LEN-th one launches the matching pulse on the same edge.
            if (sync_q[i][SYNC_STAGES-1] != out_q[i]) begin
                if (filt_q[i] == FILT_LAST) begin
                    out_d[i]  = sync_q[i][SYNC_STAGES-1];
                    rise_d[i] = sync_q[i][SYNC_STAGES-1];
                    fall_d[i] = ~sync_q[i][SYNC_STAGES-1];
                end else begin
                    filt_d[i] = filt_q[i] + FCNT_W'(1);
                end
            end

            // A pulse is counted on the edge that ends its cycle; clear wins.
            if (clear_cnt) begin
                cnt_d[i] = '0;
            end else if ((rise_q[i] || fall_q[i]) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            sat_d[i] = (cnt_d[i] == '1);
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_B) begin
        if (reset_B) begin
            sync_q <= '{default: '0};
            filt_q <= '{default: '0};
            cnt_q  <= '{default: '0};
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            sat_q  <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            sat_q  <= sat_d;
        end
    end

    // Pack per-channel counters onto the flat output bus.
    always_comb begin
        edge_cnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            edge_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign sync_out   = out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign cnt_sat    = sat_q;

endmodule

// File: tb/tb_multi_channel_sync_filter.sv
// Scoreboard bench: expected pulse events are queued as stimulus is applied
// and matched against pulses the DUT produces.
module tb_multi_channel_sync_filter;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILTER_LEN  = 3;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned LAT         = SYNC_STAGES + FILTER_LEN - 1;

    logic                    clk_B = 1'b0;
    logic                    reset_B = 1'b1;
    logic [NUM_CH-1:0]       async_in = '0;
    logic                    clear_cnt = 1'b0;
    logic [NUM_CH-1:0]       sync_out;
    logic [NUM_CH-1:0]       rise_pulse;
    logic [NUM_CH-1:0]       fall_pulse;
    logic [NUM_CH*CNT_W-1:0] edge_cnt;
    logic [NUM_CH-1:0]       cnt_sat;

    typedef struct packed {
        logic [7:0]  ch;
        logic        rise;
        logic [31:0] at;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    int unsigned edge_n   = 0;
    int unsigned tests    = 0;
    int unsigned failed   = 0;
    int unsigned both_cnt = 0;

    multi_channel_sync_filter #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_B      (clk_B),
        .reset_B    (reset_B),
        .async_in   (async_in),
        .clear_cnt  (clear_cnt),
        .sync_out   (sync_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .edge_cnt   (edge_cnt),
        .cnt_sat    (cnt_sat)
    );

    always #5 clk_B = ~clk_B;

    // Advance one edge and record any pulses seen just after it.
    task automatic tick();
        @(posedge clk_B);
        edge_n++;
        #1;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (rise_pulse[i] === 1'b1 && fall_pulse[i] === 1'b1) both_cnt++;
            if (rise_pulse[i] === 1'b1) obs_q.push_back('{ch: 8'(i), rise: 1'b1, at: edge_n});
            if (fall_pulse[i] === 1'b1) obs_q.push_back('{ch: 8'(i), rise: 1'b0, at: edge_n});
        end
    endtask

    task automatic expect_ev(input int unsigned ch, input logic rise, input int unsigned at);
        exp_q.push_back('{ch: 8'(ch), rise: rise, at: at});
    endtask

    task automatic test_reset();
        reset_B  = 1'b1;
        async_in = '0;
        for (int k = 0; k < 3; k++) tick();
        obs_q.delete();
        reset_B = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        tests++;
        if (sync_out !== 4'b0000) begin
            failed++; $display("FAIL reset_sync_out: got %b want 0000", sync_out);
        end
        tests++;
        if ({rise_pulse, fall_pulse} !== 8'h00) begin
            failed++; $display("FAIL reset_pulses: got rise=%b fall=%b want 0", rise_pulse, fall_pulse);
        end
        tests++;
        if (edge_cnt !== 16'h0000) begin
            failed++; $display("FAIL reset_edge_cnt: got %h want 0000", edge_cnt);
        end
        tests++;
        if (cnt_sat !== 4'b0000) begin
            failed++; $display("FAIL reset_cnt_sat: got %b want 0000", cnt_sat);
        end
        tests++;
        if (obs_q.size() !== 0) begin
            failed++; $display("FAIL reset_no_events: got %0d pulses want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_latency();
        int unsigned e;
        ev_t x, o;
        async_in[0] = 1'b1;
        e = edge_n + 1;
        expect_ev(0, 1'b1, e + LAT);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (edge_n == e + LAT - 1) begin
                tests++;
                if (sync_out[0] !== 1'b0) begin
                    failed++; $display("FAIL lat_early: sync_out[0]=%b at edge E+%0d want 0", sync_out[0], LAT - 1);
                end
            end
            if (edge_n == e + LAT) begin
                tests++;
                if ({sync_out[0], rise_pulse[0]} !== 2'b11) begin
                    failed++; $display("FAIL lat_accept: sync_out/rise=%b%b at edge E+%0d want 11", sync_out[0], rise_pulse[0], LAT);
                end
            end
        end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                failed++; $display("FAIL lat_event: missing ch=%0d rise=%0d edge=%0d", x.ch, x.rise, x.at);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    failed++; $display("FAIL lat_event: got ch=%0d rise=%0d edge=%0d want ch=%0d rise=%0d edge=%0d", o.ch, o.rise, o.at, x.ch, x.rise, x.at);
                end
            end
        end
        tests++;
        if (obs_q.size() !== 0) begin
            failed++; $display("FAIL lat_extra: %0d unexpected pulses want 0", obs_q.size());
            obs_q.delete();
        end
        tests++;
        if (edge_cnt[0 +: CNT_W] !== 4'd1) begin
            failed++; $display("FAIL lat_count: ch0 got %0d want 1", edge_cnt[0 +: CNT_W]);
        end
    endtask

    task automatic test_glitch();
        int unsigned e;
        ev_t x, o;
        async_in[1] = 1'b1;
        tick();
        tick();
        async_in[1] = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        tests++;
        if (sync_out[1] !== 1'b0) begin
            failed++; $display("FAIL glitch_level: sync_out[1]=%b want 0", sync_out[1]);
        end
        tests++;
        if (obs_q.size() !== 0 || edge_cnt[CNT_W +: CNT_W] !== 4'd0) begin
            failed++; $display("FAIL glitch_silent: pulses=%0d cnt=%0d want 0 0", obs_q.size(), edge_cnt[CNT_W +: CNT_W]);
            obs_q.delete();
        end
        async_in[1] = 1'b1;
        e = edge_n + 1;
        expect_ev(1, 1'b1, e + LAT);
        tick();
        tick();
        tick();
        async_in[1] = 1'b0;
        expect_ev(1, 1'b0, e + 3 + LAT);
        for (int k = 0; k < 10; k++) tick();
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                failed++; $display("FAIL glitch_event: missing ch=%0d rise=%0d edge=%0d", x.ch, x.rise, x.at);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    failed++; $display("FAIL glitch_event: got ch=%0d rise=%0d edge=%0d want ch=%0d rise=%0d edge=%0d", o.ch, o.rise, o.at, x.ch, x.rise, x.at);
                end
            end
        end
        tests++;
        if (obs_q.size() !== 0) begin
            failed++; $display("FAIL glitch_extra: %0d unexpected pulses want 0", obs_q.size());
            obs_q.delete();
        end
        tests++;
        if (edge_cnt[CNT_W +: CNT_W] !== 4'd2) begin
            failed++; $display("FAIL glitch_count: ch1 got %0d want 2", edge_cnt[CNT_W +: CNT_W]);
        end
    endtask

    task automatic test_saturation();
        ev_t x, o;
        for (int t = 0; t < 20; t++) begin
            async_in[2] = ~async_in[2];
            expect_ev(2, async_in[2], edge_n + 1 + LAT);
            for (int k = 0; k < 6; k++) tick();
            if (t == 13) begin
                tests++;
                if (cnt_sat[2] !== 1'b0) begin
                    failed++; $display("FAIL sat_early: cnt_sat[2]=%b with count %0d want 0", cnt_sat[2], edge_cnt[2*CNT_W +: CNT_W]);
                end
            end
        end
        for (int k = 0; k < 6; k++) tick();
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                failed++; $display("FAIL sat_event: missing ch=%0d rise=%0d edge=%0d", x.ch, x.rise, x.at);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    failed++; $display("FAIL sat_event: got ch=%0d rise=%0d edge=%0d want ch=%0d rise=%0d edge=%0d", o.ch, o.rise, o.at, x.ch, x.rise, x.at);
                end
            end
        end
        tests++;
        if (obs_q.size() !== 0) begin
            failed++; $display("FAIL sat_extra: %0d unexpected pulses want 0", obs_q.size());
            obs_q.delete();
        end
        tests++;
        if (edge_cnt !== 16'h0F21) begin
            failed++; $display("FAIL sat_counts: got %h want 0f21", edge_cnt);
        end
        tests++;
        if (cnt_sat !== 4'b0100) begin
            failed++; $display("FAIL sat_flag: got %b want 0100", cnt_sat);
        end
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
        tests++;
        if (edge_cnt !== 16'h0000 || cnt_sat !== 4'b0000) begin
            failed++; $display("FAIL sat_clear: cnt=%h sat=%b want 0000 0000", edge_cnt, cnt_sat);
        end
    endtask

    task automatic test_clear_collision();
        int unsigned e;
        ev_t x, o;
        async_in[3] = 1'b1;
        e = edge_n + 1;
        expect_ev(3, 1'b1, e + LAT);
        for (int k = 0; k < 10; k++) begin
            if (edge_n < e + LAT) tick();
        end
        tests++;
        if (rise_pulse[3] !== 1'b1) begin
            failed++; $display("FAIL clr_pulse: rise_pulse[3]=%b at edge E+%0d want 1", rise_pulse[3], LAT);
        end
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
        tests++;
        if (edge_cnt !== 16'h0000) begin
            failed++; $display("FAIL clr_wins: got %h want 0000", edge_cnt);
        end
        async_in = ~async_in;
        e = edge_n + 1;
        for (int unsigned i = 0; i < NUM_CH; i++) expect_ev(i, async_in[i], e + LAT);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (edge_n == e + LAT) begin
                tests++;
                if (rise_pulse !== 4'b0110 || fall_pulse !== 4'b1001) begin
                    failed++; $display("FAIL multi_pulse: rise=%b fall=%b want 0110 1001", rise_pulse, fall_pulse);
                end
            end
        end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                failed++; $display("FAIL clr_event: missing ch=%0d rise=%0d edge=%0d", x.ch, x.rise, x.at);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    failed++; $display("FAIL clr_event: got ch=%0d rise=%0d edge=%0d want ch=%0d rise=%0d edge=%0d", o.ch, o.rise, o.at, x.ch, x.rise, x.at);
                end
            end
        end
        tests++;
        if (obs_q.size() !== 0) begin
            failed++; $display("FAIL clr_extra: %0d unexpected pulses want 0", obs_q.size());
            obs_q.delete();
        end
        tests++;
        if (edge_cnt !== 16'h1111 || sync_out !== 4'b0110) begin
            failed++; $display("FAIL multi_state: cnt=%h sync=%b want 1111 0110", edge_cnt, sync_out);
        end
    endtask

    task automatic test_reset_mid_filter();
        int unsigned r;
        ev_t x, o;
        async_in[0] = 1'b1;
        tick();
        tick();
        tick();
        reset_B = 1'b1;
        tick();
        tests++;
        if (sync_out !== 4'b0000 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
            failed++; $display("FAIL rst_mid_levels: sync=%b rise=%b fall=%b want 0000", sync_out, rise_pulse, fall_pulse);
        end
        tests++;
        if (edge_cnt !== 16'h0000 || cnt_sat !== 4'b0000) begin
            failed++; $display("FAIL rst_mid_counts: cnt=%h sat=%b want 0000 0000", edge_cnt, cnt_sat);
        end
        tick();
        reset_B = 1'b0;
        r = edge_n + 1;
        for (int unsigned i = 0; i < 3; i++) expect_ev(i, 1'b1, r + LAT);
        for (int k = 0; k < 10; k++) tick();
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                failed++; $display("FAIL rst_event: missing ch=%0d rise=%0d edge=%0d", x.ch, x.rise, x.at);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    failed++; $display("FAIL rst_event: got ch=%0d rise=%0d edge=%0d want ch=%0d rise=%0d edge=%0d", o.ch, o.rise, o.at, x.ch, x.rise, x.at);
                end
            end
        end
        tests++;
        if (obs_q.size() !== 0) begin
            failed++; $display("FAIL rst_extra: %0d unexpected pulses want 0", obs_q.size());
            obs_q.delete();
        end
        tests++;
        if (edge_cnt !== 16'h0111 || sync_out !== 4'b0111) begin
            failed++; $display("FAIL rst_after: cnt=%h sync=%b want 0111 0111", edge_cnt, sync_out);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_saturation();
        test_clear_collision();
        test_reset_mid_filter();
        tests++;
        if (both_cnt !== 0) begin
            failed++; $display("FAIL exclusive_pulses: rise and fall together %0d times want 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/multi_channel_sync_filter.md
MULTI_CHANNEL_SYNC_FILTER -- requirements
Module: multi_channel_sync_filter

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent single-bit channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flop depth per channel (2..4).
REQ-003 Parameter FILTER_LEN, default 3, consecutive cycles a new value must persist before acceptance (1..15; 1 = no filtering).
REQ-004 Parameter CNT_W, default 8, width of each per-channel edge counter (2..16).
REQ-005 clk_B  input  1  single destination clock; every flop in the block is clocked on its rising edge.
REQ-006 reset_B  input  1  reset; synchronous, active-high.
REQ-007 async_in  input  NUM_CH  asynchronous level inputs, one per channel; no timing relationship to clk_B.
REQ-008 clear_cnt  input  1  synchronous clear of all edge counters and saturation flags.
REQ-009 sync_out  output  NUM_CH  registered, synchronized and filtered level per channel.
REQ-010 rise_pulse  output  NUM_CH  one-cycle pulse per channel on each accepted 0->1 transition.
REQ-011 fall_pulse  output  NUM_CH  one-cycle pulse per channel on each accepted 1->0 transition.
REQ-012 edge_cnt  output  NUM_CH*CNT_W  packed counters; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-013 cnt_sat  output  NUM_CH  per-channel flag, high while that channel's counter is saturated.

Function
REQ-014 Each channel SHALL pass async_in[i] through SYNC_STAGES flops in series; no logic between stages; the stage-1 flop is the only flop sampling async_in.
REQ-015 Each channel SHALL hold a filter counter of ceil(log2(FILTER_LEN+1)) bits; sync_last = final synchronizer stage.
REQ-016 While sync_last == sync_out[i], the filter counter SHALL be 0.
REQ-017 While sync_last != sync_out[i] and counter < FILTER_LEN-1, the counter SHALL increment by 1.
REQ-018 When sync_last != sync_out[i] and counter == FILTER_LEN-1, sync_out[i] SHALL take sync_last on that edge and the counter SHALL return to 0.
REQ-019 A difference lasting fewer than FILTER_LEN consecutive cycles SHALL leave sync_out[i] unchanged and produce no pulse.
REQ-020 Latency: an async_in change held stable from first sampling edge E SHALL appear on sync_out at edge E + SYNC_STAGES + FILTER_LEN - 1.
REQ-021 rise_pulse[i] / fall_pulse[i] SHALL be registered, high for exactly the one cycle in which sync_out[i] first shows the new value, low otherwise; never both high.
REQ-022 edge_cnt channel i SHALL increment by 1 on every cycle in which rise_pulse[i] or fall_pulse[i] is high.
REQ-023 Counters SHALL saturate at 2^CNT_W-1 (no wrap); cnt_sat[i] high exactly while the counter equals all-ones.
REQ-024 clear_cnt high SHALL set every counter and cnt_sat bit to 0 on the next edge; clear wins over a coincident pulse (that edge is not counted).
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be processed in the same cycle.

Reset
REQ-026 reset_B high at a clk_B edge SHALL clear all synchronizer flops, filter counters, sync_out, rise_pulse, fall_pulse, edge_cnt and cnt_sat to 0.
REQ-027 reset_B SHALL take priority over clear_cnt and over all input activity, including mid-filter and mid-synchronizer operation.
REQ-028 A channel whose async_in is 1 at reset release SHALL produce a normal rise_pulse and count 1 once latency REQ-020 elapses.

Verification (NUM_CH=4, SYNC_STAGES=2, FILTER_LEN=3, CNT_W=4)
REQ-029 Reset, async_in=4'b0000 steady 10 cycles -> sync_out=0, no pulses, all edge_cnt=0, cnt_sat=0.
REQ-030 async_in[0] 0->1 held before edge E -> sync_out[0]=1 and rise_pulse[0]=1 at edge E+4 only, edge_cnt ch0=1.
REQ-031 async_in[1] high for exactly 2 cycles, then low -> sync_out[1] stays 0, no pulse, counter stays 0; high for 3 cycles -> accepted rise, then fall, count 2.
REQ-032 Toggle async_in[2] every 6 cycles for 20 transitions -> edge_cnt ch2 reaches 15 and holds, cnt_sat[2]=1; clear_cnt pulse -> 0, cnt_sat[2]=0.
REQ-033 clear_cnt in same cycle as rise_pulse[3] -> edge_cnt ch3=0 afterwards; all four channels toggled on one edge -> four pulses in one cycle.
REQ-034 reset_B asserted mid-filter (counter=1) with async_in=1 held -> all outputs 0 next edge; after release, rise at reset-release edge + 4.
